// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader states and word/byte address relations
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD   = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] index);
    return base + (index << BYTE_OFFSET_BITS);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs accepted bytes big-endian into 32-bit words
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  // High in the cycle the fourth byte of a word is accepted.
  assign byte_last = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_cnt   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_last;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[15:0], byte_data};
      end
    end
  end

  // The packed word holds its value across clear so wr_data only changes on a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      word <= '0;
    end else if (byte_last && !clear) begin
      word <= {shift, byte_data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming bytes into instruction memory, holds cpu in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [31:0]           wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_new;
  logic [ADDR_WIDTH:0]   index_q, index_inc;
  logic                  take_start;
  logic                  accept;
  logic                  byte_last;
  logic                  last_word;
  logic                  done_q;

  assign count_new  = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign take_start = start && (state_q != LOAD);
  assign accept     = (state_q == LOAD) && s_valid;
  assign index_inc  = index_q + 1'b1;
  assign last_word  = byte_last && (index_inc == count_q);

  word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (take_start),
    .byte_valid (accept),
    .byte_data  (s_data),
    .byte_last  (byte_last),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (count_new == '0) ? DONE : LOAD;
      LOAD:       if (last_word) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      wr_addr <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_start) begin
        count_q <= count_new;
        index_q <= '0;
      end else if (byte_last) begin
        index_q <= index_inc;
        wr_addr <= word_byte_addr(BASE_ADDR, 32'(index_q));
      end
      // Release lags entry to DONE by a cycle so the final write lands first;
      // any new start drops the release immediately.
      done_q <= (state_q == DONE) && !start;
    end
  end

  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign done      = done_q;
  assign cpu_reset = !done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  num_words = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, wr_en, cpu_reset, busy, done;
  logic [31:0] wr_addr, wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];

  imem_loader #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [6:0] n);
    start = 1'b1;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = b;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    step();
    s_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},   32'(s_ready),   32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   wr_addr,        32'h0);
    check({tag, "_wr_data"},   wr_data,        32'h0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  logic [7:0] t2_bytes[12] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23,
                                8'h45, 8'h67, 8'hA5, 8'hC3, 8'h0F, 8'h96};
  int         t2_gaps[12]  = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 0, 1, 0};

  initial begin
    // Reset state
    step();
    step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // One word back-to-back
    addr_log.delete(); data_log.delete();
    pulse_start(7'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(s_ready), 32'd1);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    check("t1_wr_en", 32'(wr_en), 32'd1);
    check("t1_wr_addr", wr_addr, 32'h0);
    check("t1_wr_data", wr_data, 32'h20080005);
    check("t1_ready_done", 32'(s_ready), 32'd0);
    check("t1_cpu_reset_hold", 32'(cpu_reset), 32'd1);
    step();
    check("t1_wr_en_once", 32'(wr_en), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_release", 32'(cpu_reset), 32'd0);
    check("t1_nwrites", 32'(addr_log.size()), 32'd1);

    // Three words with gaps
    addr_log.delete(); data_log.delete();
    pulse_start(7'd3);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      send_byte(t2_bytes[i]);
      for (int g = 0; g < t2_gaps[i]; g++) begin
        check($sformatf("t2_gap_ready_%0d", i), 32'(s_ready), 32'd1);
        step();
      end
    end
    step();
    step();
    check("t2_nwrites", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3) begin
      check("t2_addr0", addr_log[0], 32'h0);
      check("t2_addr1", addr_log[1], 32'h4);
      check("t2_addr2", addr_log[2], 32'h8);
      check("t2_data0", data_log[0], 32'hDEADBEEF);
      check("t2_data1", data_log[1], 32'h01234567);
      check("t2_data2", data_log[2], 32'hA5C30F96);
    end
    check("t2_done", 32'(done), 32'd1);

    // Zero-length load from DONE
    addr_log.delete(); data_log.delete();
    pulse_start(7'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_cpu_reset_m1", 32'(cpu_reset), 32'd1);
    step();
    check("t3_done_m2", 32'(done), 32'd1);
    check("t3_cpu_release_m2", 32'(cpu_reset), 32'd0);
    check("t3_nwrites", 32'(addr_log.size()), 32'd0);

    // Reset mid-load
    addr_log.delete(); data_log.delete();
    pulse_start(7'd2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b1;
    step();
    check_reset_outputs("t4");
    reset = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      check("t4_idle_ready", 32'(s_ready), 32'd0);
      step();
    end
    s_valid = 1'b0;
    check("t4_nwrites", 32'(addr_log.size()), 32'd1);
    if (addr_log.size() == 1) check("t4_data0", data_log[0], 32'h11223344);

    // Count clamp to 64 words
    addr_log.delete(); data_log.delete();
    pulse_start(7'd100);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    check("t5_last_wr_en", 32'(wr_en), 32'd1);
    check("t5_last_addr", wr_addr, 32'hFC);
    check("t5_last_data", wr_data, 32'hFCFDFEFF);
    s_valid = 1'b1;
    s_data = 8'hAA;
    step();
    check("t5_ready_beyond", 32'(s_ready), 32'd0);
    step();
    check("t5_ready_beyond2", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    step();
    check("t5_nwrites", 32'(addr_log.size()), 32'd64);
    check("t5_done", 32'(done), 32'd1);

    // start mid-load ignored, then restart from DONE
    addr_log.delete(); data_log.delete();
    pulse_start(7'd2);
    send_byte(8'hC0); send_byte(8'hFF);
    pulse_start(7'd5);
    check("t6_busy_after_start", 32'(busy), 32'd1);
    send_byte(8'hEE); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    step();
    check("t6_done", 32'(done), 32'd1);
    check("t6_nwrites", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("t6_data0", data_log[0], 32'hC0FFEE01);
      check("t6_addr1", addr_log[1], 32'h4);
      check("t6_data1", data_log[1], 32'h12345678);
    end
    addr_log.delete(); data_log.delete();
    pulse_start(7'd1);
    check("t6_cpu_reset_again", 32'(cpu_reset), 32'd1);
    check("t6_done_low", 32'(done), 32'd0);
    check("t6_busy_again", 32'(busy), 32'd1);
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
    check("t6_re_addr", wr_addr, 32'h0);
    check("t6_re_data", wr_data, 32'h9ABCDEF0);
    step();
    check("t6_re_release", 32'(cpu_reset), 32'd0);
    check("t6_re_nwrites", 32'(addr_log.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle processor: accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Writes each word into instruction memory at consecutive word-aligned byte addresses. Holds the processor in reset until the last word has been written, then releases it. Sits between the external byte source and the instruction memory write port, and drives the processor's reset input.

## Interface
Parameters:
- ADDR_WIDTH, 6, word-address width of instruction memory (capacity 2^ADDR_WIDTH words)
- BASE_ADDR, 32'h0, byte address of the first word written

Ports:
- clock  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle load request; honoured only in IDLE or DONE
- num_words  in  ADDR_WIDTH+1  words to load; sampled on the cycle start is honoured
- s_valid  in  1  byte available on s_data
- s_data  in  8  stream byte
- s_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  32  byte address, word-aligned, = BASE_ADDR + 4*index
- wr_data  out  32  packed word
- cpu_reset  out  1  processor reset; high whenever a program is not fully loaded
- busy  out  1  high in LOAD
- done  out  1  high in DONE

## Operation
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, busy=0, done=0. State=IDLE, byte and word counters cleared.
- States: IDLE, LOAD, DONE.
- IDLE: on start -> LOAD. Latch count = min(num_words, 2^ADDR_WIDTH). If count=0, go -> DONE instead.
- LOAD: s_ready=1. A byte transfers when s_valid && s_ready. The first byte of a word goes to bits [31:24], the fourth to bits [7:0]. The 2-bit byte counter wraps 3->0.
- Fourth byte accepted: the word is registered, the word index increments, and the byte counter resets to 0.
- Last word's fourth byte accepted: -> DONE.
- DONE: s_ready=0, cpu_reset=0, done=1. On start: re-enter LOAD or, if the new count is 0, stay in DONE. In both cases cpu_reset returns to 1 with busy/done updated as for IDLE.
- start in LOAD: ignored; num_words not resampled.
- s_valid outside LOAD: not accepted, byte stays with source.
- s_valid gaps inside LOAD: no effect on state; s_ready stays 1.
- Reset mid-load: partial word discarded, no write issued, all outputs to reset values.
- Arithmetic: wr_addr computed as BASE_ADDR + {index, 2'b00}, 32-bit, no wrap checking beyond the count clamp.

## Timing
- Cycle N: fourth byte of a word accepted.
- Cycle N+1: wr_en=1 with valid wr_addr/wr_data. wr_en is high for exactly one cycle per word.
- A new byte may be accepted in cycle N+1, so the sustained rate is 1 byte/cycle.
- Last word: cycle N+1 carries wr_en=1 with state already DONE (s_ready=0). cpu_reset falls and done rises in cycle N+2, one cycle after the final write, so the first fetch sees the complete program.
- start honoured in cycle M: busy=1 and s_ready=1 in cycle M+1. For count=0, done=1 and cpu_reset=0 in cycle M+2.
- wr_addr/wr_data hold their last values when wr_en=0.

## Structure
- Shared package holds: state encoding localparams (IDLE/LOAD/DONE) and BYTES_PER_WORD=4. The instruction memory and processor use the same package for word/byte address relations.
- One sub-module: word_packer.
  - Contains the byte counter and 32-bit shift register.
  - Outputs: word_valid pulse and word.
  - Inputs: clear, for reset and start.
- The top level holds the FSM, count clamp, index counter, address generation and output registers.

## Test plan
- num_words=1, bytes 0x20,0x08,0x00,0x05 back-to-back -> one wr_en pulse, wr_addr=0x0, wr_data=0x20080005. cpu_reset=0 and done=1 one cycle later.
- num_words=3, 12 bytes with random s_valid gaps -> three writes at 0x0, 0x4, 0x8 with correct data. s_ready=1 throughout LOAD. No write during gaps.
- num_words=0 -> no wr_en. done=1 and cpu_reset=0 two cycles after start.
- num_words=2, reset asserted after 6 bytes -> exactly one write (word 0). All outputs at reset values the cycle after reset. No second write afterwards.
- ADDR_WIDTH=6, num_words=100 -> exactly 64 writes, last wr_addr=0xFC. Bytes beyond 256 see s_ready=0.
- start pulsed mid-LOAD -> ignored, load completes normally. start in DONE with num_words=1 -> cpu_reset back to 1, new write at 0x0, release again.
